lock_code_writer: RTL and testbench
===================================

# lock_code_writer

Programming front end for the combination lock: takes the debounced one-cycle button pulses and lets the user write a new combination into the code register that the lock FSM compares against. The user enters the new code twice. The register is updated only when both entries match. The block runs on the same slow clock as the lock FSM and the button modules, and exposes a progress digit for the BCD-to-seven-segment path.

## Interface
- CODE_LEN, 4: combination length in bits, legal range 1..9.
- DEFAULT_CODE, 4'b0110: value loaded into CODE on reset. Width is CODE_LEN.
- TIMEOUT_TICKS, 8: TICK pulses without a button pulse before an entry is aborted. Legal range 1..255.
- ERR_TICKS, 2: TICK pulses for which the ERROR state is held.

Ports:
- CLK in 1: slow system clock (divider output).
- RST in 1: synchronous, active-high reset.
- PROG_REQ in 1: one-cycle pulse that starts or restarts programming.
- PULSE0 in 1: one-cycle pulse that enters bit 0.
- PULSE1 in 1: one-cycle pulse that enters bit 1.
- TICK in 1: one-cycle time-base pulse used for timeout and error hold.
- CODE out CODE_LEN: stored combination, read by the lock FSM.
- CODE_VALID out 1: one-cycle pulse when CODE is updated.
- BUSY out 1: high in every state except IDLE.
- ERR out 1: high while in ERROR.
- BCD out 4: progress digit for the display.

## Operation
- States:
  - IDLE: PROG_REQ moves to ENTER1. Button pulses are ignored.
  - ENTER1: each accepted bit shifts into entry register A, MSB first. The bit counter increments. When the counter reaches CODE_LEN, the counter clears and the state moves to ENTER2.
  - ENTER2: same behaviour into register B. On the CODE_LEN-th bit, A is compared with B (using A and the bit being shifted into B). A match goes to COMMIT; a mismatch goes to ERROR.
  - COMMIT: lasts one cycle. CODE <= A, CODE_VALID=1, then IDLE.
  - ERROR: held until ERR_TICKS TICK pulses have been counted, then IDLE. CODE is unchanged.
- Accepted bit: exactly one of PULSE0 or PULSE1 is high. If both are high in the same cycle, the cycle is ignored: no shift, no count, and the timeout is not reset.
- Timeout: in ENTER1 or ENTER2, a tick counter increments on each TICK and clears on every accepted bit. Reaching TIMEOUT_TICKS goes to ERROR.
- PROG_REQ in ENTER1 or ENTER2: restart. Go to ENTER1, clear A, B, the bit counter and the tick counter. PROG_REQ in COMMIT or ERROR is ignored.
- BCD output:
  - IDLE and COMMIT: 0.
  - ENTER1: bits entered so far, 0..CODE_LEN-1.
  - ENTER2: bits entered so far plus 1, so the second entry reads as a new round.
  - ERROR: 4'hE.
- Reset, at any time including mid-entry: state IDLE, CODE=DEFAULT_CODE, A=B=0, all counters 0, CODE_VALID=0, BUSY=0, ERR=0, BCD=0.

## Timing
- All outputs are registered. Outputs change on the CLK edge after the triggering input cycle.
- PROG_REQ at cycle n: BUSY=1 from cycle n+1.
- Last bit of ENTER2 at cycle n:
  - COMMIT at n+1, with CODE updated and CODE_VALID high at n+1.
  - IDLE and BUSY=0 at n+2.
- Mismatch at cycle n: ERR=1 from n+1.
- Timeout: ERROR is entered on the cycle after the TIMEOUT_TICKS-th TICK.
- ERROR exit: IDLE on the cycle after the ERR_TICKS-th TICK counted in ERROR. A TICK coincident with ERROR entry is not counted.
- A button pulse coincident with a TICK: the bit is accepted and the tick counter clears to 0.
- Back-to-back pulses on consecutive cycles are all accepted.

## Structure
- Shared package holds the state encoding (IDLE, ENTER1, ENTER2, COMMIT, ERROR) and the constant BCD_ERR = 4'hE. The lock FSM and the display path reuse both.
- One natural sub-module: tick_timer, a loadable down-counter on TICK with a clear input and a done output. It is instantiated once and shared between the timeout and the error hold, since those never overlap.
- Counter widths: bit counter is clog2(CODE_LEN+1) bits; tick counter is 8 bits.

## Test plan
- Reset then idle: CODE=0110, BUSY=0, BCD=0. Pulses with no PROG_REQ leave CODE at 0110.
- PROG_REQ, then 1,0,1,1 and 1,0,1,1: BCD steps 0,1,2,3 then 1,2,3,4. CODE=1011 and CODE_VALID is high for one cycle. BUSY=0 two cycles after the last pulse.
- PROG_REQ, then 1,0,1,1 and 1,0,0,1: ERR=1 and BCD=E for 2 TICKs. Return to IDLE with CODE=0110.
- PROG_REQ, two bits, then 8 TICKs with no pulses: ERROR, then IDLE, CODE unchanged. Second check: PULSE0 and PULSE1 high together mid-entry leaves the count unchanged.
- PROG_REQ asserted again after 3 bits: BCD returns to 0, and a full fresh double entry of 0001 commits CODE=0001.
- RST asserted mid-ENTER2: next cycle IDLE, CODE=0110, all outputs at their reset values.

Source files
------------

// File: rtl/lock_code_writer_pkg.sv
// Shared definitions for the combination-lock programming path, reused by the lock FSM and display logic.
package lock_code_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENTER1 = 3'd1,
    ST_ENTER2 = 3'd2,
    ST_COMMIT = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  localparam logic [3:0] BCD_ERR    = 4'hE;
  localparam int         TICK_CNT_W = 8;

endpackage

// File: rtl/lock_code_writer_if.sv
// Button/time-base inputs and code/status outputs of the code writer.
interface lock_code_writer_if #(
  parameter int CODE_LEN = 4
);

  logic                PROG_REQ;
  logic                PULSE0;
  logic                PULSE1;
  logic                TICK;
  logic [CODE_LEN-1:0] CODE;
  logic                CODE_VALID;
  logic                BUSY;
  logic                ERR;
  logic [3:0]          BCD;

  modport master (
    output PROG_REQ, PULSE0, PULSE1, TICK,
    input  CODE, CODE_VALID, BUSY, ERR, BCD
  );

  modport slave (
    input  PROG_REQ, PULSE0, PULSE1, TICK,
    output CODE, CODE_VALID, BUSY, ERR, BCD
  );

endinterface

// File: rtl/lock_code_writer_tick_timer.sv
// Loadable down-counter on TICK; done_o flags the TICK that drains the last count.
module lock_code_writer_tick_timer
  import lock_code_writer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  clr_i,
  input  logic                  tick_i,
  input  logic [TICK_CNT_W-1:0] load_val_i,
  output logic                  done_o
);

  logic [TICK_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (clr_i) begin
      cnt_d = '0;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TICK_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = tick_i && (cnt_q == TICK_CNT_W'(1));

endmodule

// File: rtl/lock_code_writer.sv
// Double-entry code programming FSM: the new code is written only when both entries agree.
module lock_code_writer
  import lock_code_writer_pkg::*;
#(
  parameter int                  CODE_LEN      = 4,
  parameter logic [CODE_LEN-1:0] DEFAULT_CODE  = 4'b0110,
  parameter int                  TIMEOUT_TICKS = 8,
  parameter int                  ERR_TICKS     = 2
) (
  input  logic                CLK,
  input  logic                RST,
  lock_code_writer_if.slave   bus
);

  localparam int                    CNT_W    = $clog2(CODE_LEN + 1);
  localparam logic [CNT_W-1:0]      LAST_BIT = CNT_W'(CODE_LEN - 1);
  localparam logic [TICK_CNT_W-1:0] TO_LD    = TICK_CNT_W'(TIMEOUT_TICKS);
  localparam logic [TICK_CNT_W-1:0] ERR_LD   = TICK_CNT_W'(ERR_TICKS);

  state_e                state_q, state_d;
  logic [CODE_LEN-1:0]   a_q, a_d, b_q, b_d, code_q, code_d;
  logic [CNT_W-1:0]      bitcnt_q, bitcnt_d;
  logic                  code_valid_q, code_valid_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic [3:0]            bcd_q, bcd_d;

  logic                  bit_acc, bit_val;
  logic [CODE_LEN-1:0]   a_shift, b_shift;
  logic                  tmr_load, tmr_clr, tmr_done;
  logic [TICK_CNT_W-1:0] tmr_val;

  // Both pulses together is an ambiguous press and is dropped entirely.
  assign bit_acc = bus.PULSE0 ^ bus.PULSE1;
  assign bit_val = bus.PULSE1;
  assign a_shift = CODE_LEN'({a_q, bit_val});
  assign b_shift = CODE_LEN'({b_q, bit_val});

  lock_code_writer_tick_timer u_tick_timer (
    .clk        (CLK),
    .rst        (RST),
    .load_i     (tmr_load),
    .clr_i      (tmr_clr),
    .tick_i     (bus.TICK),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    bitcnt_d = bitcnt_q;
    code_d   = code_q;
    tmr_load = 1'b0;
    tmr_clr  = 1'b0;
    tmr_val  = TO_LD;

    case (state_q)
      ST_IDLE: begin
        if (bus.PROG_REQ) begin
          state_d  = ST_ENTER1;
          a_d      = '0;
          b_d      = '0;
          bitcnt_d = '0;
          tmr_load = 1'b1;
        end
      end

      ST_ENTER1, ST_ENTER2: begin
        if (bus.PROG_REQ) begin
          state_d  = ST_ENTER1;
          a_d      = '0;
          b_d      = '0;
          bitcnt_d = '0;
          tmr_load = 1'b1;
        end else if (bit_acc) begin
          // An accepted bit restarts the timeout even if a TICK lands on the same cycle.
          tmr_load = 1'b1;
          bitcnt_d = bitcnt_q + CNT_W'(1);
          if (state_q == ST_ENTER1) begin
            a_d = a_shift;
            if (bitcnt_q == LAST_BIT) begin
              bitcnt_d = '0;
              state_d  = ST_ENTER2;
            end
          end else begin
            b_d = b_shift;
            if (bitcnt_q == LAST_BIT) begin
              bitcnt_d = '0;
              if (a_q == b_shift) begin
                state_d  = ST_COMMIT;
                code_d   = a_q;
                tmr_load = 1'b0;
                tmr_clr  = 1'b1;
              end else begin
                state_d = ST_ERROR;
                tmr_val = ERR_LD;
              end
            end
          end
        end else if (tmr_done) begin
          state_d  = ST_ERROR;
          bitcnt_d = '0;
          tmr_load = 1'b1;
          tmr_val  = ERR_LD;
        end
      end

      ST_COMMIT: begin
        state_d = ST_IDLE;
        tmr_clr = 1'b1;
      end

      ST_ERROR: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
          tmr_clr = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they appear registered on the following edge.
  always_comb begin
    code_valid_d = (state_d == ST_COMMIT);
    busy_d       = (state_d != ST_IDLE);
    err_d        = (state_d == ST_ERROR);
    bcd_d        = 4'h0;
    case (state_d)
      ST_ENTER1: bcd_d = 4'(bitcnt_d);
      ST_ENTER2: bcd_d = 4'(bitcnt_d) + 4'h1;
      ST_ERROR:  bcd_d = BCD_ERR;
      default:   bcd_d = 4'h0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      bitcnt_q     <= '0;
      code_q       <= DEFAULT_CODE;
      code_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      bcd_q        <= 4'h0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      bitcnt_q     <= bitcnt_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      bcd_q        <= bcd_d;
    end
  end

  assign bus.CODE       = code_q;
  assign bus.CODE_VALID = code_valid_q;
  assign bus.BUSY       = busy_q;
  assign bus.ERR        = err_q;
  assign bus.BCD        = bcd_q;

endmodule

// File: tb/tb_lock_code_writer.sv
// Cycle-by-cycle vector bench for lock_code_writer with an expected-output scoreboard.
module tb_lock_code_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  lock_code_writer_if #(.CODE_LEN(4)) bus ();

  lock_code_writer #(
    .CODE_LEN      (4),
    .DEFAULT_CODE  (4'b0110),
    .TIMEOUT_TICKS (8),
    .ERR_TICKS     (2)
  ) u_dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    string      name;
    logic       rst, prog, p0, p1, tick;
    logic [3:0] code;
    logic       cv, busy, err;
    logic [3:0] bcd;
  } vec_t;

  typedef struct {
    string       name;
    logic [10:0] outs;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_applied = 0;
  int   n_miss    = 0;

  task automatic add(input string nm, input logic r, pr, a0, a1, tk,
                     input logic [3:0] cd, input logic v, b, e, input logic [3:0] bc);
    vec_t t;
    t.name = nm; t.rst = r; t.prog = pr; t.p0 = a0; t.p1 = a1; t.tick = tk;
    t.code = cd; t.cv = v; t.busy = b; t.err = e; t.bcd = bc;
    vecs.push_back(t);
  endtask

  task automatic apply(input vec_t v);
    exp_t        e;
    logic [10:0] act;
    @(negedge clk);
    rst          = v.rst;
    bus.PROG_REQ = v.prog;
    bus.PULSE0   = v.p0;
    bus.PULSE1   = v.p1;
    bus.TICK     = v.tick;
    e.name = v.name;
    e.outs = {v.code, v.cv, v.busy, v.err, v.bcd};
    sb.push_back(e);
    @(posedge clk);
    #1;
    act = {bus.CODE, bus.CODE_VALID, bus.BUSY, bus.ERR, bus.BCD};
    e = sb.pop_front();
    n_applied++;
    if (act !== e.outs) begin
      n_miss++;
      $display("FAIL %s: got code=%b cv=%b busy=%b err=%b bcd=%h, expected code=%b cv=%b busy=%b err=%b bcd=%h",
               e.name, act[10:7], act[6], act[5], act[4], act[3:0],
               e.outs[10:7], e.outs[6], e.outs[5], e.outs[4], e.outs[3:0]);
    end
  endtask

  task automatic step(input string nm, input logic r, pr, a0, a1, tk,
                      input logic [3:0] cd, input logic v, b, e, input logic [3:0] bc);
    vec_t t;
    t.name = nm; t.rst = r; t.prog = pr; t.p0 = a0; t.p1 = a1; t.tick = tk;
    t.code = cd; t.cv = v; t.busy = b; t.err = e; t.bcd = bc;
    apply(t);
  endtask

  initial begin
    bus.PROG_REQ = 1'b0;
    bus.PULSE0   = 1'b0;
    bus.PULSE1   = 1'b0;
    bus.TICK     = 1'b0;

    //   name        rst pr p0 p1 tk  code  cv bsy err bcd
    add("rst0",       1, 0, 0, 0, 0, 4'h6, 0, 0, 0, 4'h0);
    add("rst1",       1, 0, 0, 0, 0, 4'h6, 0, 0, 0, 4'h0);
    add("idle_p1",    0, 0, 0, 1, 0, 4'h6, 0, 0, 0, 4'h0);
    add("idle_p0",    0, 0, 1, 0, 1, 4'h6, 0, 0, 0, 4'h0);
    add("idle_both",  0, 0, 1, 1, 0, 4'h6, 0, 0, 0, 4'h0);
    // Matching double entry of 1011
    add("ok_prog",    0, 1, 0, 0, 0, 4'h6, 0, 1, 0, 4'h0);
    add("ok_a0",      0, 0, 0, 1, 0, 4'h6, 0, 1, 0, 4'h1);
    add("ok_a1",      0, 0, 1, 0, 0, 4'h6, 0, 1, 0, 4'h2);
    add("ok_a2",      0, 0, 0, 1, 0, 4'h6, 0, 1, 0, 4'h3);
    add("ok_a3",      0, 0, 0, 1, 0, 4'h6, 0, 1, 0, 4'h1);
    add("ok_b0",      0, 0, 0, 1, 0, 4'h6, 0, 1, 0, 4'h2);
    add("ok_b1",      0, 0, 1, 0, 0, 4'h6, 0, 1, 0, 4'h3);
    add("ok_b2",      0, 0, 0, 1, 0, 4'h6, 0, 1, 0, 4'h4);
    add("ok_commit",  0, 0, 0, 1, 0, 4'hB, 1, 1, 0, 4'h0);
    add("ok_idle",    0, 0, 0, 0, 0, 4'hB, 0, 0, 0, 4'h0);
    add("ok_idle2",   0, 0, 0, 0, 0, 4'hB, 0, 0, 0, 4'h0);
    // Mismatch 1011 vs 1001; last bit carries a TICK that must not count toward the hold
    add("mm_rst",     1, 0, 0, 0, 0, 4'h6, 0, 0, 0, 4'h0);
    add("mm_prog",    0, 1, 0, 0, 0, 4'h6, 0, 1, 0, 4'h0);
    add("mm_a0",      0, 0, 0, 1, 0, 4'h6, 0, 1, 0, 4'h1);
    add("mm_a1",      0, 0, 1, 0, 0, 4'h6, 0, 1, 0, 4'h2);
    add("mm_a2",      0, 0, 0, 1, 0, 4'h6, 0, 1, 0, 4'h3);
    add("mm_a3",      0, 0, 0, 1, 0, 4'h6, 0, 1, 0, 4'h1);
    add("mm_b0",      0, 0, 0, 1, 0, 4'h6, 0, 1, 0, 4'h2);
    add("mm_b1",      0, 0, 1, 0, 0, 4'h6, 0, 1, 0, 4'h3);
    add("mm_b2",      0, 0, 1, 0, 0, 4'h6, 0, 1, 0, 4'h4);
    add("mm_b3_err",  0, 0, 0, 1, 1, 4'h6, 0, 1, 1, 4'hE);
    add("mm_hold0",   0, 0, 0, 0, 0, 4'h6, 0, 1, 1, 4'hE);
    add("mm_prog_ig", 0, 1, 0, 0, 0, 4'h6, 0, 1, 1, 4'hE);
    add("mm_tick1",   0, 0, 0, 0, 1, 4'h6, 0, 1, 1, 4'hE);
    add("mm_hold1",   0, 0, 0, 0, 0, 4'h6, 0, 1, 1, 4'hE);
    add("mm_tick2",   0, 0, 0, 0, 1, 4'h6, 0, 0, 0, 4'h0);
    add("mm_idle",    0, 0, 0, 0, 0, 4'h6, 0, 0, 0, 4'h0);
    // Timeout: pulse+TICK reloads, double pulse counts only as a TICK
    add("to_prog",    0, 1, 0, 0, 0, 4'h6, 0, 1, 0, 4'h0);
    for (int i = 0; i < 3; i++) add("to_pre_tick", 0, 0, 0, 0, 1, 4'h6, 0, 1, 0, 4'h0);
    add("to_bit_tick",0, 0, 0, 1, 1, 4'h6, 0, 1, 0, 4'h1);
    add("to_bit",     0, 0, 1, 0, 0, 4'h6, 0, 1, 0, 4'h2);
    add("to_both",    0, 0, 1, 1, 1, 4'h6, 0, 1, 0, 4'h2);
    for (int i = 0; i < 6; i++) add("to_tick", 0, 0, 0, 0, 1, 4'h6, 0, 1, 0, 4'h2);
    add("to_expire",  0, 0, 0, 0, 1, 4'h6, 0, 1, 1, 4'hE);
    add("to_hold",    0, 0, 0, 0, 1, 4'h6, 0, 1, 1, 4'hE);
    add("to_exit",    0, 0, 0, 0, 1, 4'h6, 0, 0, 0, 4'h0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Restart after three bits, then fresh double entry of 0001
    step("rs_prog",   0, 1, 0, 0, 0, 4'h6, 0, 1, 0, 4'h0);
    step("rs_a0",     0, 0, 0, 1, 0, 4'h6, 0, 1, 0, 4'h1);
    step("rs_a1",     0, 0, 0, 1, 0, 4'h6, 0, 1, 0, 4'h2);
    step("rs_a2",     0, 0, 0, 1, 0, 4'h6, 0, 1, 0, 4'h3);
    step("rs_restart",0, 1, 0, 0, 0, 4'h6, 0, 1, 0, 4'h0);
    step("rs_n0",     0, 0, 1, 0, 0, 4'h6, 0, 1, 0, 4'h1);
    step("rs_n1",     0, 0, 1, 0, 0, 4'h6, 0, 1, 0, 4'h2);
    step("rs_n2",     0, 0, 1, 0, 0, 4'h6, 0, 1, 0, 4'h3);
    step("rs_n3",     0, 0, 0, 1, 0, 4'h6, 0, 1, 0, 4'h1);
    step("rs_m0",     0, 0, 1, 0, 0, 4'h6, 0, 1, 0, 4'h2);
    step("rs_m1",     0, 0, 1, 0, 0, 4'h6, 0, 1, 0, 4'h3);
    step("rs_m2",     0, 0, 1, 0, 0, 4'h6, 0, 1, 0, 4'h4);
    step("rs_commit", 0, 0, 0, 1, 0, 4'h1, 1, 1, 0, 4'h0);
    step("rs_idle",   0, 0, 0, 0, 0, 4'h1, 0, 0, 0, 4'h0);

    // Reset in the middle of the second entry
    step("mr_prog",   0, 1, 0, 0, 0, 4'h1, 0, 1, 0, 4'h0);
    step("mr_a0",     0, 0, 0, 1, 0, 4'h1, 0, 1, 0, 4'h1);
    step("mr_a1",     0, 0, 1, 0, 0, 4'h1, 0, 1, 0, 4'h2);
    step("mr_a2",     0, 0, 0, 1, 0, 4'h1, 0, 1, 0, 4'h3);
    step("mr_a3",     0, 0, 0, 1, 0, 4'h1, 0, 1, 0, 4'h1);
    step("mr_b0",     0, 0, 1, 0, 0, 4'h1, 0, 1, 0, 4'h2);
    step("mr_rst",    1, 0, 0, 1, 1, 4'h6, 0, 0, 0, 4'h0);
    step("mr_idle",   0, 0, 0, 0, 0, 4'h6, 0, 0, 0, 4'h0);
    step("mr_ignore", 0, 0, 0, 1, 0, 4'h6, 0, 0, 0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule
